// File: rtl/control_sequencer.sv
// Control sequencer: Moore FSM driving datapath strobes through fetch and execute steps.
module control_sequencer #(
  parameter int unsigned OP_W = 5,
  parameter int unsigned IR_W = 32,
  parameter int unsigned ALU_W = 5,
  parameter logic [ALU_W-1:0] INC_CODE = ALU_W'(5'b11111),
  parameter logic [ALU_W-1:0] ADD_CODE = ALU_W'(5'b00011)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [IR_W-1:0]  ir,
  input  logic             con_out,
  input  logic             mem_ready,
  output logic [8:0]       ctl_in,
  output logic [7:0]       ctl_out,
  output logic [5:0]       gpr_ctl,
  output logic             Conin,
  output logic             memread,
  output logic             memwrite,
  output logic [ALU_W-1:0] ALUCode,
  output logic             run
);

  // ctl_in bit positions
  localparam int unsigned HI_IN    = 8;
  localparam int unsigned LO_IN    = 7;
  localparam int unsigned Z_IN     = 6;
  localparam int unsigned PC_IN    = 5;
  localparam int unsigned MDR_IN   = 4;
  localparam int unsigned MAR_IN   = 3;
  localparam int unsigned Y_IN     = 2;
  localparam int unsigned OPORT_IN = 1;
  localparam int unsigned IR_IN    = 0;

  // ctl_out bit positions
  localparam int unsigned HI_OUT    = 7;
  localparam int unsigned LO_OUT    = 6;
  localparam int unsigned ZLO_OUT   = 4;
  localparam int unsigned PC_OUT    = 3;
  localparam int unsigned MDR_OUT   = 2;
  localparam int unsigned IPORT_OUT = 1;
  localparam int unsigned C_OUT     = 0;

  // gpr_ctl bit positions
  localparam int unsigned GRA    = 5;
  localparam int unsigned GRB    = 4;
  localparam int unsigned GRC    = 3;
  localparam int unsigned R_IN   = 2;
  localparam int unsigned R_OUT  = 1;
  localparam int unsigned BA_OUT = 0;

  // opcode values
  localparam int unsigned OPC_LD     = 0;
  localparam int unsigned OPC_LDI    = 1;
  localparam int unsigned OPC_ST     = 2;
  localparam int unsigned OPC_ALU_LO = 3;
  localparam int unsigned OPC_ALU_HI = 11;
  localparam int unsigned OPC_ADDI   = 12;
  localparam int unsigned OPC_BR     = 19;
  localparam int unsigned OPC_JR     = 20;
  localparam int unsigned OPC_JAL    = 21;
  localparam int unsigned OPC_IN     = 22;
  localparam int unsigned OPC_OUT    = 23;
  localparam int unsigned OPC_MFHI   = 24;
  localparam int unsigned OPC_MFLO   = 25;
  localparam int unsigned OPC_HALT   = 27;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state, state_next;

  logic [OP_W-1:0] op;
  logic is_ld, is_ldi, is_st, is_alu, is_addi, is_br, is_jr, is_jal;
  logic is_in, is_out, is_mfhi, is_mflo, is_halt;
  logic unused_ir;

  assign op        = ir[IR_W-1 -: OP_W];
  assign unused_ir = ^ir[IR_W-OP_W-1:0];

  // Opcode class decode; anything unlisted falls through as a nop.
  always_comb begin
    is_ld   = (op == OP_W'(OPC_LD));
    is_ldi  = (op == OP_W'(OPC_LDI));
    is_st   = (op == OP_W'(OPC_ST));
    is_alu  = (op >= OP_W'(OPC_ALU_LO)) && (op <= OP_W'(OPC_ALU_HI));
    is_addi = (op == OP_W'(OPC_ADDI));
    is_br   = (op == OP_W'(OPC_BR));
    is_jr   = (op == OP_W'(OPC_JR));
    is_jal  = (op == OP_W'(OPC_JAL));
    is_in   = (op == OP_W'(OPC_IN));
    is_out  = (op == OP_W'(OPC_OUT));
    is_mfhi = (op == OP_W'(OPC_MFHI));
    is_mflo = (op == OP_W'(OPC_MFLO));
    is_halt = (op == OP_W'(OPC_HALT));
  end

  // State register with synchronous clear overriding every state.
  always_ff @(posedge clock) begin
    if (clear) state <= S_RST;
    else       state <= state_next;
  end

  // Next-state: memory steps hold until mem_ready; execute length depends on opcode.
  always_comb begin
    state_next = state;
    case (state)
      S_RST: state_next = S_T0;
      S_T0:  state_next = S_T1;
      S_T1:  state_next = mem_ready ? S_T2 : S_T1;
      S_T2:  state_next = S_T3;
      S_T3: begin
        if (is_halt)                                   state_next = S_HALT;
        else if (is_ld || is_ldi || is_st || is_alu ||
                 is_addi || is_br || is_jal)           state_next = S_T4;
        else                                           state_next = S_T0;
      end
      S_T4:  state_next = is_jal ? S_T0 : S_T5;
      S_T5:  state_next = (is_ld || is_st || is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld)      state_next = mem_ready ? S_T7 : S_T6;
        else if (is_st) state_next = S_T7;
        else            state_next = S_T0;
      end
      S_T7: begin
        if (is_st) state_next = mem_ready ? S_T0 : S_T7;
        else       state_next = S_T0;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  // Strobe decode from state and opcode; con_out gates PCIn in the branch step.
  always_comb begin
    ctl_in   = '0;
    ctl_out  = '0;
    gpr_ctl  = '0;
    Conin    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    ALUCode  = '0;
    run      = (state != S_HALT);
    case (state)
      S_T0: begin
        ctl_out[PC_OUT] = 1'b1;
        ctl_in[MAR_IN]  = 1'b1;
        ctl_in[Z_IN]    = 1'b1;
        ALUCode         = INC_CODE;
      end
      S_T1: begin
        ctl_out[ZLO_OUT] = 1'b1;
        ctl_in[PC_IN]    = 1'b1;
        memread          = 1'b1;
        ctl_in[MDR_IN]   = 1'b1;
      end
      S_T2: begin
        ctl_out[MDR_OUT] = 1'b1;
        ctl_in[IR_IN]    = 1'b1;
      end
      S_T3: begin
        if (is_ld || is_ldi || is_st) begin
          gpr_ctl[GRB]    = 1'b1;
          gpr_ctl[BA_OUT] = 1'b1;
          ctl_in[Y_IN]    = 1'b1;
        end else if (is_alu || is_addi) begin
          gpr_ctl[GRB]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          ctl_in[Y_IN]   = 1'b1;
        end else if (is_br) begin
          gpr_ctl[GRA]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          Conin          = 1'b1;
        end else if (is_jr) begin
          gpr_ctl[GRA]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          ctl_in[PC_IN]  = 1'b1;
        end else if (is_jal) begin
          gpr_ctl[GRB]    = 1'b1;
          gpr_ctl[R_IN]   = 1'b1;
          ctl_out[PC_OUT] = 1'b1;
        end else if (is_in) begin
          gpr_ctl[GRA]       = 1'b1;
          gpr_ctl[R_IN]      = 1'b1;
          ctl_out[IPORT_OUT] = 1'b1;
        end else if (is_out) begin
          gpr_ctl[GRA]     = 1'b1;
          gpr_ctl[R_OUT]   = 1'b1;
          ctl_in[OPORT_IN] = 1'b1;
        end else if (is_mfhi) begin
          gpr_ctl[GRA]    = 1'b1;
          gpr_ctl[R_IN]   = 1'b1;
          ctl_out[HI_OUT] = 1'b1;
        end else if (is_mflo) begin
          gpr_ctl[GRA]    = 1'b1;
          gpr_ctl[R_IN]   = 1'b1;
          ctl_out[LO_OUT] = 1'b1;
        end
      end
      S_T4: begin
        if (is_ld || is_ldi || is_st || is_addi) begin
          ctl_out[C_OUT] = 1'b1;
          ctl_in[Z_IN]   = 1'b1;
          ALUCode        = ADD_CODE;
        end else if (is_alu) begin
          gpr_ctl[GRC]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          ctl_in[Z_IN]   = 1'b1;
          ALUCode        = ALU_W'(op);
        end else if (is_br) begin
          ctl_out[PC_OUT] = 1'b1;
          ctl_in[Y_IN]    = 1'b1;
        end else if (is_jal) begin
          gpr_ctl[GRA]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          ctl_in[PC_IN]  = 1'b1;
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          ctl_out[ZLO_OUT] = 1'b1;
          ctl_in[MAR_IN]   = 1'b1;
        end else if (is_ldi || is_alu || is_addi) begin
          ctl_out[ZLO_OUT] = 1'b1;
          gpr_ctl[GRA]     = 1'b1;
          gpr_ctl[R_IN]    = 1'b1;
        end else if (is_br) begin
          ctl_out[C_OUT] = 1'b1;
          ctl_in[Z_IN]   = 1'b1;
          ALUCode        = ADD_CODE;
        end
      end
      S_T6: begin
        if (is_ld) begin
          memread        = 1'b1;
          ctl_in[MDR_IN] = 1'b1;
        end else if (is_st) begin
          gpr_ctl[GRA]   = 1'b1;
          gpr_ctl[R_OUT] = 1'b1;
          ctl_in[MDR_IN] = 1'b1;
        end else if (is_br) begin
          ctl_out[ZLO_OUT] = 1'b1;
          ctl_in[PC_IN]    = con_out;
        end
      end
      S_T7: begin
        if (is_ld) begin
          ctl_out[MDR_OUT] = 1'b1;
          gpr_ctl[GRA]     = 1'b1;
          gpr_ctl[R_IN]    = 1'b1;
        end else if (is_st) begin
          memwrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: strobe vectors checked cycle by cycle.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        con_out;
  logic        mem_ready;
  logic [8:0]  ctl_in;
  logic [7:0]  ctl_out;
  logic [5:0]  gpr_ctl;
  logic        Conin;
  logic        memread;
  logic        memwrite;
  logic [4:0]  ALUCode;
  logic        run;

  int checks = 0;
  int errors = 0;

  // ctl_in = {HiIn,LoIn,ZIn,PCIn,MDRIn,MARIn,YIn,OPortIn,IRIn}
  localparam logic [8:0] ZIN = 9'h040, PCIN = 9'h020, MDRIN = 9'h010, MARIN = 9'h008;
  localparam logic [8:0] YIN = 9'h004, OPORTIN = 9'h002, IRIN = 9'h001;
  // ctl_out = {HiOut,LoOut,ZHiOut,ZLoOut,PCOut,MDROut,IPortOut,COut}
  localparam logic [7:0] HIOUT = 8'h80, LOOUT = 8'h40, ZLOOUT = 8'h10, PCOUT = 8'h08;
  localparam logic [7:0] MDROUT = 8'h04, IPORTOUT = 8'h02, COUT = 8'h01;
  // gpr_ctl = {Gra,Grb,Grc,RIn,ROut,BAOut}
  localparam logic [5:0] GRA = 6'h20, GRB = 6'h10, GRC = 6'h08, RIN = 6'h04, ROUT = 6'h02, BAOUT = 6'h01;

  control_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .ir        (ir),
    .con_out   (con_out),
    .mem_ready (mem_ready),
    .ctl_in    (ctl_in),
    .ctl_out   (ctl_out),
    .gpr_ctl   (gpr_ctl),
    .Conin     (Conin),
    .memread   (memread),
    .memwrite  (memwrite),
    .ALUCode   (ALUCode),
    .run       (run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packs an expected output set in the same order as the observed vector.
  function automatic logic [31:0] mk(input logic [8:0] ci, input logic [7:0] co,
                                     input logic [5:0] g, input logic cn, input logic mr,
                                     input logic mw, input logic [4:0] alu, input logic rn);
    return {ci, co, g, cn, mr, mw, alu, rn};
  endfunction

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then compare the full output set.
  task automatic step(input string tag, input logic [31:0] exp);
    @(posedge clock);
    #1;
    check(tag, {ctl_in, ctl_out, gpr_ctl, Conin, memread, memwrite, ALUCode, run}, exp);
  endtask

  logic [31:0] e_rst, e_t0, e_t1, e_t2, e_idle, e_halt;
  logic [31:0] e_ld3, e_ld4, e_ld5;

  task automatic fetch();
    step("t1", e_t1);
    step("t2", e_t2);
  endtask

  logic [4:0]  t3_op [8];
  logic [31:0] t3_exp [8];

  initial begin
    e_rst  = mk('0, '0, '0, 0, 0, 0, 5'd0, 1);
    e_t0   = mk(ZIN | MARIN, PCOUT, '0, 0, 0, 0, 5'h1f, 1);
    e_t1   = mk(PCIN | MDRIN, ZLOOUT, '0, 0, 1, 0, 5'd0, 1);
    e_t2   = mk(IRIN, MDROUT, '0, 0, 0, 0, 5'd0, 1);
    e_idle = mk('0, '0, '0, 0, 0, 0, 5'd0, 1);
    e_halt = mk('0, '0, '0, 0, 0, 0, 5'd0, 0);
    e_ld3  = mk(YIN, '0, GRB | BAOUT, 0, 0, 0, 5'd0, 1);
    e_ld4  = mk(ZIN, COUT, '0, 0, 0, 0, 5'd3, 1);
    e_ld5  = mk(MARIN, ZLOOUT, '0, 0, 0, 0, 5'd0, 1);

    t3_op[0] = 5'd20; t3_exp[0] = mk(PCIN, '0, GRA | ROUT, 0, 0, 0, 5'd0, 1);
    t3_op[1] = 5'd22; t3_exp[1] = mk('0, IPORTOUT, GRA | RIN, 0, 0, 0, 5'd0, 1);
    t3_op[2] = 5'd23; t3_exp[2] = mk(OPORTIN, '0, GRA | ROUT, 0, 0, 0, 5'd0, 1);
    t3_op[3] = 5'd24; t3_exp[3] = mk('0, HIOUT, GRA | RIN, 0, 0, 0, 5'd0, 1);
    t3_op[4] = 5'd25; t3_exp[4] = mk('0, LOOUT, GRA | RIN, 0, 0, 0, 5'd0, 1);
    t3_op[5] = 5'd26; t3_exp[5] = e_idle;
    t3_op[6] = 5'd13; t3_exp[6] = e_idle;
    t3_op[7] = 5'd30; t3_exp[7] = e_idle;

    clear = 1'b1; ir = {5'd21, 27'd0}; con_out = 1'b0; mem_ready = 1'b0;

    // Reset held two cycles, then one RST cycle and T0.
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("rst", {ctl_in, ctl_out, gpr_ctl, Conin, memread, memwrite, ALUCode, run}, e_rst);
    step("t0", e_t0);

    // Fetch with three wait cycles, then jal.
    for (int i = 0; i < 4; i++) step("t1_wait", e_t1);
    mem_ready = 1'b1;
    step("t2", e_t2);
    step("jal_t3", mk('0, PCOUT, GRB | RIN, 0, 0, 0, 5'd0, 1));
    step("jal_t4", mk(PCIN, '0, GRA | ROUT, 0, 0, 0, 5'd0, 1));
    step("jal_t0", e_t0);

    // R-type sub.
    ir = {5'd4, 27'd0};
    fetch();
    step("sub_t3", mk(YIN, '0, GRB | ROUT, 0, 0, 0, 5'd0, 1));
    step("sub_t4", mk(ZIN, '0, GRC | ROUT, 0, 0, 0, 5'd4, 1));
    step("sub_t5", mk('0, ZLOOUT, GRA | RIN, 0, 0, 0, 5'd0, 1));
    step("sub_t0", e_t0);

    // Branch not taken, then taken.
    for (int c = 0; c < 2; c++) begin
      ir = {5'd19, 27'd0};
      con_out = c[0];
      fetch();
      step("br_t3", mk('0, '0, GRA | ROUT, 1, 0, 0, 5'd0, 1));
      step("br_t4", mk(YIN, PCOUT, '0, 0, 0, 0, 5'd0, 1));
      step("br_t5", mk(ZIN, COUT, '0, 0, 0, 0, 5'd3, 1));
      step("br_t6", mk(c[0] ? PCIN : 9'h000, ZLOOUT, '0, 0, 0, 0, 5'd0, 1));
      step("br_t0", e_t0);
    end
    con_out = 1'b0;

    // Load with a memory wait in T6.
    ir = {5'd0, 27'd0};
    fetch();
    step("ld_t3", e_ld3);
    step("ld_t4", e_ld4);
    step("ld_t5", e_ld5);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ld_t6", mk(MDRIN, '0, '0, 0, 1, 0, 5'd0, 1));
    mem_ready = 1'b1;
    step("ld_t7", mk('0, MDROUT, GRA | RIN, 0, 0, 0, 5'd0, 1));
    step("ld_t0", e_t0);

    // Store with a memory wait in T7.
    ir = {5'd2, 27'd0};
    fetch();
    step("st_t3", e_ld3);
    step("st_t4", e_ld4);
    step("st_t5", e_ld5);
    step("st_t6", mk(MDRIN, '0, GRA | ROUT, 0, 0, 0, 5'd0, 1));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("st_t7", mk('0, '0, '0, 0, 0, 1, 5'd0, 1));
    mem_ready = 1'b1;
    step("st_t0", e_t0);

    // ldi and addi.
    ir = {5'd1, 27'd0};
    fetch();
    step("ldi_t3", e_ld3);
    step("ldi_t4", e_ld4);
    step("ldi_t5", mk('0, ZLOOUT, GRA | RIN, 0, 0, 0, 5'd0, 1));
    step("ldi_t0", e_t0);
    ir = {5'd12, 27'd0};
    fetch();
    step("addi_t3", mk(YIN, '0, GRB | ROUT, 0, 0, 0, 5'd0, 1));
    step("addi_t4", e_ld4);
    step("addi_t5", mk('0, ZLOOUT, GRA | RIN, 0, 0, 0, 5'd0, 1));
    step("addi_t0", e_t0);

    // Single-step instructions, nop and undefined opcodes.
    for (int k = 0; k < 8; k++) begin
      ir = {t3_op[k], 27'd0};
      fetch();
      step($sformatf("op%0d_t3", t3_op[k]), t3_exp[k]);
      step($sformatf("op%0d_t0", t3_op[k]), e_t0);
    end

    // Clear during a load T6 wait aborts the access.
    ir = {5'd0, 27'd0};
    fetch();
    step("ab_t3", e_ld3);
    step("ab_t4", e_ld4);
    step("ab_t5", e_ld5);
    mem_ready = 1'b0;
    step("ab_t6", mk(MDRIN, '0, '0, 0, 1, 0, 5'd0, 1));
    clear = 1'b1;
    step("ab_rst", e_rst);
    clear = 1'b0;
    step("ab_t0", e_t0);
    mem_ready = 1'b1;

    // Halt holds until clear, ignoring mem_ready.
    ir = {5'd27, 27'd0};
    fetch();
    step("halt_t3", e_idle);
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      step("halt", e_halt);
    end
    clear = 1'b1;
    step("halt_rst", e_rst);
    clear = 1'b0;
    mem_ready = 1'b1;
    step("halt_t0", e_t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OP_W, default 5: opcode width; opcode field is ir[IR_W-1 -: OP_W].
REQ-002 Parameter IR_W, default 32: instruction register width.
REQ-003 Parameter ALU_W, default 5: ALUCode width.
REQ-004 Parameter INC_CODE, default 5'b11111: ALU code for PC+1. Parameter ADD_CODE, default 5'b00011: ALU code for address/immediate add.
REQ-005 One clock; reset is synchronous and active-high. Ports are named clock and clear.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 clear  in  1  synchronous active-high reset.
REQ-008 ir  in  IR_W  current instruction register contents.
REQ-009 con_out  in  1  branch condition flag from the datapath CON flip-flop.
REQ-010 mem_ready  in  1  memory completion; sampled while memread or memwrite is high.
REQ-011 ctl_in  out  9  {HiIn,LoIn,ZIn,PCIn,MDRIn,MARIn,YIn,OPortIn,IRIn}.
REQ-012 ctl_out  out  8  {HiOut,LoOut,ZHiOut,ZLoOut,PCOut,MDROut,IPortOut,COut}.
REQ-013 gpr_ctl  out  6  {Gra,Grb,Grc,RIn,ROut,BAOut}.
REQ-014 Conin, memread, memwrite  out  1 each  CON latch, memory read strobe, memory write strobe.
REQ-015 ALUCode  out  ALU_W  ALU operation select; 0 when no ALU op is active.
REQ-016 run  out  1  high except in HALT.

Function
REQ-017 States: RST, T0..T7, HALT. Outputs are Moore-decoded from state and opcode, plus con_out in T6. Every strobe not listed for a state is 0.
REQ-018 RST: all strobes 0, run=1; next state T0.
REQ-019 T0: PCOut, MARIn, ZIn, ALUCode=INC_CODE.
REQ-020 T1: ZLoOut, PCIn, memread, MDRIn. State holds T1 with the same strobes while mem_ready=0 and advances to T2 on the edge where mem_ready=1.
REQ-021 T2: MDROut, IRIn.
REQ-022 Opcodes: ld=0, ldi=1, st=2, R-type ALU=3..11, addi=12, br=19, jr=20, jal=21, in=22, out=23, mfhi=24, mflo=25, nop=26, halt=27. Any undefined opcode executes as nop.
REQ-023 ld: T3 Grb,BAOut,YIn; T4 COut,ZIn,ALUCode=ADD_CODE; T5 ZLoOut,MARIn; T6 memread,MDRIn (held until mem_ready, as in REQ-020); T7 MDROut,Gra,RIn; then T0.
REQ-024 ldi: T3 and T4 as ld; T5 ZLoOut,Gra,RIn; then T0.
REQ-025 st: T3–T5 as ld; T6 Gra,ROut,MDRIn; T7 memwrite, held until mem_ready; then T0.
REQ-026 R-type: T3 Grb,ROut,YIn; T4 Grc,ROut,ZIn,ALUCode=opcode; T5 ZLoOut,Gra,RIn; then T0.
REQ-027 addi: T3 Grb,ROut,YIn; T4 COut,ZIn,ALUCode=ADD_CODE; T5 ZLoOut,Gra,RIn; then T0.
REQ-028 br: T3 Gra,ROut,Conin; T4 PCOut,YIn; T5 COut,ZIn,ALUCode=ADD_CODE; T6 ZLoOut, with PCIn=con_out; then T0.
REQ-029 jr: T3 Gra,ROut,PCIn; then T0.
REQ-030 jal: T3 Grb,RIn,PCOut; T4 Gra,ROut,PCIn; then T0.
REQ-031 in: T3 Gra,RIn,IPortOut. out: T3 Gra,ROut,OPortIn. mfhi: T3 Gra,RIn,HiOut. mflo: T3 Gra,RIn,LoOut. Each then goes to T0.
REQ-032 nop: T3 has no strobes; then T0.
REQ-033 halt: T3 goes to HALT. In HALT all strobes are 0 and run=0; the only exit is clear.
REQ-034 The mem_ready wait has no timeout. mem_ready=1 outside a memory state is ignored.

Reset
REQ-035 clear=1 at any rising edge forces state RST on that edge, overriding any wait or HALT. The cycle after is RST, with all strobes 0 and run=1.
REQ-036 clear asserted mid-instruction (including during a T1 or T6/T7 memory wait) aborts the instruction. memread/memwrite are low from the following cycle on.

Verification
REQ-037 Reset: clear=1 for 2 cycles, then 0 -> one RST cycle with all outputs 0 and run=1, then T0 with PCOut=MARIn=ZIn=1 and ALUCode=5'b11111.
REQ-038 Fetch wait: mem_ready=0 for 3 cycles in T1 -> memread=MDRIn=1 for 4 cycles, then T2 with MDROut=IRIn=1.
REQ-039 jal: ir opcode 21 -> T3 Grb=RIn=PCOut=1; T4 Gra=ROut=PCIn=1; next cycle is T0. Instruction totals 5 cycles with mem_ready tied high.
REQ-040 R-type: ir opcode 4 (sub) -> T4 has ALUCode=5'd4 with Grc=ROut=ZIn=1; T5 ZLoOut=Gra=RIn=1.
REQ-041 br: con_out=0 -> PCIn=0 in T6; rerun with con_out=1 -> PCIn=1 in T6.
REQ-042 halt/abort: opcode 27 -> run=0 held for 10+ cycles until clear. clear during a ld T6 wait -> RST next cycle, memread=0.
